data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 158 +++++++++++++++
 tb/tb_data_mem.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// data_mem: single-port word-addressed data memory for the MEM stage.
// Each access holds DM_busy for LATENCY cycles, spends one RESP cycle, then returns to IDLE.
// Illegal commands (misaligned, out of range, or cmd 2'b11) get a one-cycle DM_err
// and cause no other effect.
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_mem_addr,
    input  logic [1:0]  MEM_mem_cmd,
    input  logic [31:0] MEM_mem_din,
    output logic [31:0] DM_mem_dout,
    output logic        DM_busy,
    output logic        DM_err
);

    // Word index width. Byte address bits [AW+1:2] select the word.
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    // Bus command encoding. These values match sys_defs.
    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    // With a single-cycle latency, the access completes on the acceptance edge.
    localparam bit         LAT_ONE  = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic            is_store_q;
    logic [31:0]     din_q;
    logic [31:0]     dout_q;
    logic [31:0]     dout_d;
    logic            run_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            in_idle_c;
    logic            cmd_rw_c;
    logic            addr_ok_c;
    logic            accept_c;
    logic            reject_c;
    logic            fire_c;
    logic            fire_store_c;
    logic [AW-1:0]   fire_idx_c;
    logic [31:0]     fire_din_c;

    // Decode the presented command. Upper address bits must be zero, so addresses do not alias.
    always_comb begin
        in_idle_c = (state_q == S_IDLE) && run_q;
        cmd_rw_c  = (MEM_mem_cmd == BUS_LOAD) || (MEM_mem_cmd == BUS_STORE);
        addr_ok_c = (MEM_mem_addr[1:0] == 2'b00) &&
                    (MEM_mem_addr[31:AW+2] == '0);
        accept_c  = in_idle_c && cmd_rw_c && addr_ok_c;
        reject_c  = in_idle_c && (MEM_mem_cmd != BUS_NONE) && !accept_c;
    end

    // Select the array access for this edge: live inputs on a single-cycle
    // accept, otherwise the values captured at acceptance.
    always_comb begin
        fire_c       = (accept_c && LAT_ONE) ||
                       ((state_q == S_WAIT) && (cnt_q == 4'd1));
        fire_store_c = is_store_q;
        fire_idx_c   = idx_q;
        fire_din_c   = din_q;
        if (state_q == S_IDLE) begin
            fire_store_c = (MEM_mem_cmd == BUS_STORE);
            fire_idx_c   = MEM_mem_addr[AW+1:2];
            fire_din_c   = MEM_mem_din;
        end
    end

    // Next load-data value: it changes only when a LOAD completes.
    always_comb begin
        dout_d = dout_q;
        if (fire_c && !fire_store_c) begin
            dout_d = mem_q[fire_idx_c];
        end
    end

    // Stall and error flags are asserted in the same cycle as the request.
    always_comb begin
        DM_busy     = accept_c || (state_q == S_WAIT);
        DM_err      = reject_c;
        DM_mem_dout = dout_q;
    end

    // Reset-release qualifier. It blocks acceptance while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Access sequencer: captures the request, counts the latency, and returns through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            is_store_q <= 1'b0;
            din_q      <= 32'h0;
            dout_q     <= 32'h0;
        end else begin
            dout_q <= dout_d;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        idx_q      <= MEM_mem_addr[AW+1:2];
                        is_store_q <= (MEM_mem_cmd == BUS_STORE);
                        din_q      <= MEM_mem_din;
                        if (LAT_ONE) begin
                            state_q <= S_RESP;
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Storage array. Reset does not clear it; a store is written only on its completing edge.
    always_ff @(posedge clk) begin
        if (fire_c && fire_store_c) begin
            mem_q[fire_idx_c] <= fire_din_c;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed and random checks of data_mem against a word-array reference model.
// Three instances cover LATENCY 2/1/15.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic [1:0]  cmd  [3];
    logic        busy [3];
    logic        err  [3];

    int unsigned depth [3] = '{1024, 16, 64};
    int unsigned lat   [3] = '{2, 1, 15};

    logic [31:0] model   [3][1024];
    bit          written [3][1024];
    logic [31:0] exp_dout [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dm0 (
        .clk(clk), .rst(rst), .MEM_mem_addr(addr[0]), .MEM_mem_cmd(cmd[0]),
        .MEM_mem_din(din[0]), .DM_mem_dout(dout[0]), .DM_busy(busy[0]), .DM_err(err[0]));
    data_mem #(.DEPTH_WORDS(16), .LATENCY(1)) u_dm1 (
        .clk(clk), .rst(rst), .MEM_mem_addr(addr[1]), .MEM_mem_cmd(cmd[1]),
        .MEM_mem_din(din[1]), .DM_mem_dout(dout[1]), .DM_busy(busy[1]), .DM_err(err[1]));
    data_mem #(.DEPTH_WORDS(64), .LATENCY(15)) u_dm2 (
        .clk(clk), .rst(rst), .MEM_mem_addr(addr[2]), .MEM_mem_cmd(cmd[2]),
        .MEM_mem_din(din[2]), .DM_mem_dout(dout[2]), .DM_busy(busy[2]), .DM_err(err[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus request. Called just after a rising edge; returns just after the rising edge that begins the next free cycle.
    task automatic access(input int i, input logic [1:0] c, input logic [31:0] a,
                          input logic [31:0] d, input bit toggle, input string tag);
        bit          legal;
        int unsigned w;
        legal = ((c == 2'b01) || (c == 2'b10)) && (a % 4 == 0) && (a < depth[i] * 4);
        w     = a / 4;
        cmd[i] = c; addr[i] = a; din[i] = d;
        @(negedge clk);
        check({tag, ":busy_T"}, 32'(busy[i]), 32'(legal));
        check({tag, ":err_T"}, 32'(err[i]), 32'((c != 2'b00) && !legal));
        check({tag, ":dout_T"}, dout[i], exp_dout[i]);
        if (legal) begin
            for (int k = 1; k < int'(lat[i]); k++) begin
                @(posedge clk); #1;
                if (toggle) begin
                    addr[i] = $urandom; din[i] = $urandom;
                end
                @(negedge clk);
                check({tag, ":busy_wait"}, 32'(busy[i]), 32'd1);
                check({tag, ":err_wait"}, 32'(err[i]), 32'd0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            if (c == 2'b01) exp_dout[i] = model[i][w];
            else begin
                model[i][w]   = d;
                written[i][w] = 1'b1;
            end
            check({tag, ":busy_resp"}, 32'(busy[i]), 32'd0);
            check({tag, ":err_resp"}, 32'(err[i]), 32'd0);
            check({tag, ":dout_resp"}, dout[i], exp_dout[i]);
        end
        @(posedge clk); #1;
        cmd[i] = 2'b00;
    endtask

    task automatic nop(input int i, input string tag);
        cmd[i] = 2'b00;
        @(negedge clk);
        check({tag, ":busy"}, 32'(busy[i]), 32'd0);
        check({tag, ":err"}, 32'(err[i]), 32'd0);
        check({tag, ":dout"}, dout[i], exp_dout[i]);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r, w;
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            cmd[i] = 2'b00; addr[i] = 32'h0; din[i] = 32'h0; exp_dout[i] = 32'h0;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset:busy", 32'(busy[i]), 32'd0);
            check("reset:err", 32'(err[i]), 32'd0);
            check("reset:dout", dout[i], 32'h0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Store, then a back-to-back load of the same word.
        access(0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, "st10");
        access(0, 2'b01, 32'h10, 32'h0, 1'b0, "ld10");
        // Misaligned and illegal-command rejections.
        access(0, 2'b01, 32'h6, 32'h0, 1'b0, "ld_mis");
        access(0, 2'b11, 32'h10, 32'h0, 1'b0, "cmd11");
        nop(0, "nop0");
        // Range boundary: no aliasing above the top word.
        access(0, 2'b10, 32'h0, 32'h0BADF00D, 1'b0, "st0");
        access(0, 2'b10, 32'hFFC, 32'hCAFEF00D, 1'b0, "stFFC");
        access(0, 2'b10, 32'h1000, 32'h11111111, 1'b0, "st1000");
        access(0, 2'b01, 32'hFFC, 32'h0, 1'b0, "ldFFC");
        access(0, 2'b01, 32'h0, 32'h0, 1'b0, "ld0_noalias");
        access(0, 2'b01, 32'h8000_0010, 32'h0, 1'b0, "ld_hi");
        access(0, 2'b01, 32'h10, 32'h0, 1'b0, "ld10_b");

        // Reset in the middle of a store discards the store.
        access(0, 2'b10, 32'h20, 32'hAAAA5555, 1'b0, "st20");
        cmd[0] = 2'b10; addr[0] = 32'h20; din[0] = 32'h1234;
        @(negedge clk);
        check("rst_mid:busy_T", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) exp_dout[i] = 32'h0;
        check("rst_mid:busy", 32'(busy[0]), 32'd0);
        check("rst_mid:dout", dout[0], 32'h0);
        @(negedge clk);
        rst = 1'b0; cmd[0] = 2'b00;
        @(posedge clk); #1;
        access(0, 2'b01, 32'h20, 32'h0, 1'b0, "ld20_after_rst");
        access(0, 2'b01, 32'hFFC, 32'h0, 1'b0, "ldFFC_after_rst");

        // LATENCY=1: alternating stores and loads across the whole array.
        for (int k = 0; k < 16; k++) begin
            access(1, 2'b10, 32'(k * 4), $urandom, 1'b0, "l1_st");
            access(1, 2'b01, 32'(k * 4), 32'h0, 1'b0, "l1_ld");
        end

        // LATENCY=15: inputs toggle during WAIT; the captured address and data must be used.
        access(2, 2'b10, 32'h40, 32'h5A5AA5A5, 1'b1, "l15_st");
        access(2, 2'b10, 32'h44, 32'h01020304, 1'b1, "l15_st2");
        access(2, 2'b01, 32'h40, 32'h0, 1'b1, "l15_ld");
        access(2, 2'b01, 32'h44, 32'h0, 1'b1, "l15_ld2");
        access(2, 2'b10, 32'h100, 32'h0, 1'b0, "l15_oor");

        // Random mix of commands per instance.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < ((i == 2) ? 12 : 60); n++) begin
                r = $urandom_range(0, 9);
                w = $urandom_range(0, depth[i] - 1);
                v = $urandom;
                case (r)
                    0: nop(i, "rnd_nop");
                    1: access(i, 2'b11, $urandom, v, 1'b0, "rnd_cmd11");
                    2: access(i, 2'($urandom_range(1, 2)), 32'(w * 4 + $urandom_range(1, 3)),
                              v, 1'b0, "rnd_mis");
                    3: access(i, 2'($urandom_range(1, 2)),
                              32'(depth[i] * 4 + $urandom_range(0, 4000) * 4), v, 1'b0, "rnd_oor");
                    4, 5, 6: access(i, 2'b10, 32'(w * 4), v, (i == 2), "rnd_st");
                    default: begin
                        if (written[i][w]) access(i, 2'b01, 32'(w * 4), v, (i == 2), "rnd_ld");
                        else access(i, 2'b10, 32'(w * 4), v, (i == 2), "rnd_st2");
                    end
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
